linelength_feature: RTL

- Front-end feature extractor for the seizure-detection datapath.
- Consumes raw signed EEG samples and produces the sliding-window line-length feature: the sum of |x[n]-x[n-1]| over the last WIN_LEN samples.
- Its dout/dout_valid pair is the producer side of the baseline window-averaging chain. It emits one feature word per accepted sample, 25 bits wide by default, once the window is full.

---
 rtl/linelength_feature_pkg.sv | 10 +
 rtl/linelength_feature_ll_window_ram.sv | 24 ++
 rtl/linelength_feature.sv | 104 ++++++++++
 3 files changed

// File: rtl/linelength_feature_pkg.sv
// Shared constants for the seizure-detection front end.
package linelength_feature_pkg;

    localparam int SAMPLE_W_DEF   = 16;
    localparam int WIN_LEN_DEF    = 250;
    localparam int PTR_W_DEF      = 8;
    localparam int OUT_W_DEF      = 25;
    localparam int SAMPLE_RATE_HZ = 250;

endpackage

// File: rtl/linelength_feature_ll_window_ram.sv
// Circular buffer of absolute differences, synchronous read so it maps onto block RAM.
module ll_window_ram #(
    parameter int DEPTH  = 250,
    parameter int WIDTH  = 17,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the pre-write contents when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/linelength_feature.sv
// Sliding-window line-length feature: sum of |x[n]-x[n-1]| over the last WIN_LEN samples.
module linelength_feature
    import linelength_feature_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int WIN_LEN  = WIN_LEN_DEF,
    parameter int PTR_W    = PTR_W_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] din,
    input  logic                       din_valid,
    input  logic                       en,
    output logic [OUT_W-1:0]           dout,
    output logic                       dout_valid,
    output logic                       data_valid
);

    localparam int AD_W   = SAMPLE_W + 1;
    localparam int FILL_W = PTR_W + 1;

    function automatic logic [AD_W-1:0] abs_val(input logic signed [AD_W-1:0] v);
        return v[AD_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic signed [SAMPLE_W-1:0] prev_p0;
    logic                       first_p0;
    logic [OUT_W-1:0]           sum_p0;
    logic [PTR_W-1:0]           wptr_p0;
    logic [FILL_W-1:0]          fill_p0;
    logic                       vld_p1;
    logic                       data_valid_p1;

    logic                       accept;
    logic                       full;
    logic signed [AD_W-1:0]     diff;
    logic [AD_W-1:0]            ad;
    logic [AD_W-1:0]            rd_data;
    logic [AD_W-1:0]            old;
    logic [OUT_W-1:0]           sum_nxt;
    logic [PTR_W-1:0]           wptr_nxt;
    logic [FILL_W-1:0]          fill_nxt;

    assign accept   = din_valid & ~en;
    assign full     = (fill_p0 == FILL_W'(WIN_LEN));
    assign diff     = AD_W'(din) - AD_W'(prev_p0);
    assign ad       = first_p0 ? '0 : abs_val(diff);
    assign old      = full ? rd_data : '0;
    assign sum_nxt  = sum_p0 + OUT_W'(ad) - OUT_W'(old);
    assign fill_nxt = full ? fill_p0 : fill_p0 + 1'b1;

    always_comb begin
        wptr_nxt = wptr_p0;
        if (accept)
            wptr_nxt = (wptr_p0 == PTR_W'(WIN_LEN - 1)) ? '0 : wptr_p0 + 1'b1;
    end

    // Reading at the next pointer keeps rd_data equal to buf[wptr] one edge ahead,
    // so the oldest entry is ready even when samples arrive every cycle.
    ll_window_ram #(
        .DEPTH (WIN_LEN),
        .WIDTH (AD_W),
        .ADDR_W(PTR_W)
    ) u_ram (
        .clk    (clk),
        .we     (accept),
        .wr_addr(wptr_p0),
        .wr_data(ad),
        .rd_addr(wptr_nxt),
        .rd_data(rd_data)
    );

    // Accumulate stage -> registered feature output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_p0       <= '0;
            first_p0      <= 1'b1;
            sum_p0        <= '0;
            wptr_p0       <= '0;
            fill_p0       <= '0;
            vld_p1        <= 1'b0;
            data_valid_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (accept) begin
                prev_p0  <= din;
                first_p0 <= 1'b0;
                sum_p0   <= sum_nxt;
                wptr_p0  <= wptr_nxt;
                fill_p0  <= fill_nxt;
                if (fill_nxt == FILL_W'(WIN_LEN)) begin
                    vld_p1        <= 1'b1;
                    data_valid_p1 <= 1'b1;
                end
            end
        end
    end

    assign dout       = sum_p0;
    assign dout_valid = vld_p1;
    assign data_valid = data_valid_p1;

endmodule
